mc_control_fsm: RTL
===================

# mc_control_fsm

Multicycle control unit for the RV32I datapath. It is a Moore state machine plus an ALU decoder that sequences fetch, decode, execute, memory and writeback. It drives IRWrite, which latches the instruction that addresses the register file, and the register-file outputs RD1/RD2 are then captured by the A/WriteData stage one cycle later. It also drives every enable and mux select on the multicycle datapath.

## Interface
Parameters: none (encodings come from the shared package).
- clk  input  1  datapath clock, all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- op  input  7  Instr[6:0]
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  OldPC/Instr register enable
- ResultSrc  output  2  Result mux: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  output  2  00 WriteData, 01 ImmExt, 10 constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register-file write enable
- Illegal  output  1  unsupported-opcode pulse
- state_o  output  4  current state, for debug

## Operation
- Supported instructions: lw(0000011), sw(0100011), R-type(0110011: add, sub, and, or, slt), I-ALU(0010011: addi, andi, ori, slti), branch(1100011: beq, bne), jal(1101111).
- States and Moore outputs. Any field not listed is 0.
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUOp=01, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-ALU, JAL for jal, BRANCH for branch. Any other op goes to FETCH.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER and EXECUTEI→ALUWB→FETCH.
  - JAL→ALUWB.
  - BRANCH→FETCH.
- PCWrite = PCUpdate | (Branch & taken). taken = Zero for funct3=000, ~Zero for funct3=001, and 0 for any other funct3.
- ImmSrc is combinational from op: lw/I-ALU/others 00, sw 01, branch 10, jal 11.
- ALU decode:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 decodes funct3: 000 gives sub if op[5]&funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- Illegal=1 for exactly the DECODE cycle in which op is unsupported. The FSM then returns to FETCH, so the instruction acts as a nop apart from PC+4.

## Timing
- State register updates on posedge clk. Every output is combinational from state, op, funct3, funct7b5 and Zero; there are no registered outputs.
- Reset: rst=1 at a posedge sets state to FETCH. While rst=1, every output except state_o is forced to 0, so no PC, memory or register write happens. The first cycle after rst deasserts is FETCH with IRWrite=1.
- rst asserted mid-instruction aborts that instruction at the next edge. A store or register write that is in progress in that cycle is suppressed by the output gating.
- Cycles per instruction: lw 5, sw 4, R 4, I-ALU 4, jal 4, branch 3, illegal 2.
- PCWrite in BRANCH is evaluated from Zero in the same cycle. Zero must be settled from A − WriteData before the edge.
- A/WriteData capture RD1/RD2 at the end of DECODE. Every state after DECODE that selects A or WriteData (ALUSrcA=10, ALUSrcB=00) therefore sees the operands of the current instruction.

## Structure
- Shared package mc_ctrl_pkg holds:
  - state enum (4 bits) with FETCH=0 through BRANCH=10;
  - opcode localparams;
  - ALUOp, ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- One sub-module, mc_alu_decoder: combinational, taking ALUOp, funct3, funct7b5 and op[5] and producing ALUControl.
- The top contains the state register, next-state logic, output decode, PCWrite logic, ImmSrc decode and reset gating.

## Test plan
- Reset: hold rst 3 cycles, release → state_o=0, IRWrite=1, PCWrite=1, and all outputs 0 while rst was high.
- lw (op=0000011) → state sequence 0,1,2,3,4,0. MEMREAD has AdrSrc=1. MEMWB has ResultSrc=01, RegWrite=1. ImmSrc=00 throughout.
- sw → 0,1,2,5,0. MemWrite=1 only in MEMWRITE. ImmSrc=01.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER. With funct7b5=0 → 000. slt funct3=010 → 101.
- Branches:
  - beq with Zero=1 → PCWrite=1 in BRANCH;
  - beq with Zero=0 → PCWrite=0;
  - bne with Zero=0 → PCWrite=1.
  - Each takes 3 cycles.
- Illegal op 0000000 → Illegal=1 for one cycle in DECODE, then FETCH, with no RegWrite or MemWrite. rst asserted during MEMWRITE → MemWrite=0 in that cycle and FETCH follows.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the RV32I multicycle control unit: state codes, opcodes
// and every datapath select field driven by mc_control_fsm.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_IALU) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder: maps ALUOp plus instruction function bits to ALUControl.
// Purely combinational, no state.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Only R-type (op[5]=1) can encode sub; addi with bit30 set is still add.
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle RV32I datapath; 2-5 cycles per instruction.
// All outputs are combinational from state and instruction fields, forced to 0 during rst.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] state_o
);

  state_t     r_state;
  state_t     w_next;

  logic       w_pc_update;
  logic       w_branch;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_reg_write;
  logic       w_taken;
  logic [1:0] w_imm_src;
  logic [2:0] w_alu_control;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTER;
          OP_IALU:      w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BRANCH:    w_next = S_BRANCH;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BRANCH:   w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = RES_ALUOUT;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_WDATA;
    w_alu_op     = ALUOP_ADD;
    w_reg_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_pc_update  = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        w_alu_src_a = SRCA_A;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        w_alu_src_a = SRCA_A;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        w_alu_src_a = SRCA_A;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_JAL: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = SRCA_A;
        w_alu_op    = ALUOP_SUB;
        w_branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_imm_src = IMM_I;
    case (op)
      OP_SW:     w_imm_src = IMM_S;
      OP_BRANCH: w_imm_src = IMM_B;
      OP_JAL:    w_imm_src = IMM_J;
      default:   w_imm_src = IMM_I;
    endcase
  end

  assign w_illegal = (r_state == S_DECODE) && !op_supported(op);

  mc_alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (w_alu_control)
  );

  // Gating on rst keeps an aborted store or writeback from reaching memory or the regfile.
  assign PCWrite    = ~rst & (w_pc_update | (w_branch & w_taken));
  assign AdrSrc     = ~rst & w_adr_src;
  assign MemWrite   = ~rst & w_mem_write;
  assign IRWrite    = ~rst & w_ir_write;
  assign ResultSrc  = rst ? 2'b00 : w_result_src;
  assign ALUSrcA    = rst ? 2'b00 : w_alu_src_a;
  assign ALUSrcB    = rst ? 2'b00 : w_alu_src_b;
  assign ALUControl = rst ? 3'b000 : w_alu_control;
  assign ImmSrc     = rst ? 2'b00 : w_imm_src;
  assign RegWrite   = ~rst & w_reg_write;
  assign Illegal    = ~rst & w_illegal;
  assign state_o    = r_state;

endmodule
